// File: rtl/count_second.sv
// count_second: 0..59 seconds counter with run/stop and set buttons and a one-cycle minute carry.
// Define SEC_DEBOUNCE_EN to insert a DB_CYCLES stability filter on both buttons.
module count_second #(
    parameter int CLK_DIV   = 50_000_000,
    parameter int DB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       set_sec,
    input  logic       clr_sec,
    output logic [5:0] sec,
    output logic       count_min,
    output logic       running
);

    localparam int         PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int         BTN_START = 0;
    localparam int         BTN_SET   = 1;
    localparam logic [5:0] SEC_MAX   = 6'd59;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    if ((CLK_DIV < 2) || (CLK_DIV > (1 << 26)) || (DB_CYCLES < 1)) begin : gBadParams
        $error("count_second: CLK_DIV must be 2..2^26 and DB_CYCLES at least 1");
    end

    logic [1:0] btnRaw;
    logic [1:0] syncMeta_q;
    logic [1:0] syncOut_q;
    logic [1:0] syncValid_q;
    logic [1:0] level;
    logic [1:0] levelPrev_q;
    logic [1:0] armed_q;
    logic [1:0] armed_d;
    logic [1:0] pulse;

    assign btnRaw = {set_sec, start_stop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncMeta_q  <= '0;
            syncOut_q   <= '0;
            syncValid_q <= '0;
        end else begin
            syncMeta_q  <= btnRaw;
            syncOut_q   <= syncMeta_q;
            syncValid_q <= {syncValid_q[0], 1'b1};
        end
    end

`ifdef SEC_DEBOUNCE_EN
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [DBW-1:0] dbCnt_q [2];
    logic [DBW-1:0] dbCnt_d [2];
    logic [1:0]     filt_q;
    logic [1:0]     filt_d;

    // The filtered level flips only after DB_CYCLES consecutive samples disagree with it.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            dbCnt_d[i] = '0;
            if (syncOut_q[i] != filt_q[i]) begin
                if (dbCnt_q[i] == DBW'(DB_CYCLES - 1)) begin
                    filt_d[i] = syncOut_q[i];
                end else begin
                    dbCnt_d[i] = dbCnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                dbCnt_q[i] <= '0;
            end
            filt_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                dbCnt_q[i] <= dbCnt_d[i];
            end
            filt_q <= filt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = syncOut_q;
`endif

    // A button arms only once it has really been seen released after reset,
    // so a button held through reset cannot fake a press as the pipeline fills.
    assign armed_d = armed_q | ({2{syncValid_q[1]}} & ~syncOut_q);
    assign pulse   = level & ~levelPrev_q & armed_q;

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [5:0]    sec_q;
    logic [5:0]    sec_d;
    logic          countMin_q;
    logic          countMin_d;
    logic          tick;
    logic          startPulse;
    logic          setPulse;
    logic [5:0]    secInc;

    assign startPulse = pulse[BTN_START];
    assign setPulse   = pulse[BTN_SET];
    assign tick       = (state_q == RUN) && (presc_q == PW'(CLK_DIV - 1));
    assign secInc     = (sec_q >= SEC_MAX) ? 6'd0 : sec_q + 6'd1;

    always_comb begin
        state_d = state_q;
        if (startPulse) begin
            state_d = (state_q == RUN) ? STOP : RUN;
        end
    end

    // The prescaler only advances while RUN persists across the edge, so a fresh
    // start always gives a full CLK_DIV cycles before the first tick.
    always_comb begin
        presc_d    = '0;
        sec_d      = sec_q;
        countMin_d = 1'b0;
        if (!clr_sec && (state_q == RUN) && (state_d == RUN) && !tick) begin
            presc_d = presc_q + 1'b1;
        end
        if (clr_sec) begin
            sec_d = '0;
        end else if (tick) begin
            sec_d      = secInc;
            countMin_d = (sec_q == SEC_MAX);
        end else if (setPulse && (state_q == STOP)) begin
            sec_d = secInc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= STOP;
            presc_q     <= '0;
            sec_q       <= '0;
            countMin_q  <= 1'b0;
            levelPrev_q <= '0;
            armed_q     <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            countMin_q  <= countMin_d;
            levelPrev_q <= level;
            armed_q     <= armed_d;
        end
    end

    assign sec       = sec_q;
    assign count_min = countMin_q;
    assign running   = (state_q == RUN);

endmodule

// File: tb/tb_count_second.sv
// tb_count_second: randomized self-checking bench for count_second against a behavioural seconds model.
// Button latency and glitch expectations follow SEC_DEBOUNCE_EN when it is defined for the build.
module tb_count_second;

    localparam int CLK_DIV = 4;
    localparam int DB      = 4;
`ifdef SEC_DEBOUNCE_EN
    localparam int FILT_N     = DB;
    localparam int ACT_DLY    = 3;
    localparam int GLITCH_EXP = 1;
`else
    localparam int FILT_N     = 1;
    localparam int ACT_DLY    = 2;
    localparam int GLITCH_EXP = 2;
`endif
    localparam int HOLD   = FILT_N + 1;
    localparam int SETTLE = ACT_DLY + FILT_N + 4;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       start_stop = 1'b0;
    logic       set_sec    = 1'b0;
    logic       clr_sec    = 1'b0;
    logic [5:0] sec;
    logic       count_min;
    logic       running;

    int checks = 0;
    int errors = 0;

    int secM;
    bit cmM;
    bit runM;
    int phaseM;
    int edgeNo;
    int runLen [2];
    bit lastS  [2];
    bit filtM  [2];
    bit armedM [2];
    int startDue [$];
    int setDue   [$];

    int exp3 [3] = '{59, 0, 1};

    count_second #(
        .CLK_DIV  (CLK_DIV),
        .DB_CYCLES(DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_stop(start_stop),
        .set_sec   (set_sec),
        .clr_sec   (clr_sec),
        .sec       (sec),
        .count_min (count_min),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        secM   = 0;
        cmM    = 1'b0;
        runM   = 1'b0;
        phaseM = 0;
        edgeNo = 0;
        startDue.delete();
        setDue.delete();
        for (int b = 0; b < 2; b++) begin
            runLen[b] = 0;
            lastS[b]  = 1'b0;
            filtM[b]  = 1'b0;
            armedM[b] = 1'b0;
        end
    endtask

    // One clock edge of the reference: a press is recognised once FILT_N equal
    // samples are seen, and its effect lands ACT_DLY edges after the last one.
    task automatic modelStep(input bit stIn, input bit setIn, input bit clrIn);
        bit s;
        bit doStart;
        bit doSet;
        bit wasRun;
        bit tickM;
        edgeNo++;
        for (int b = 0; b < 2; b++) begin
            s = (b == 0) ? stIn : setIn;
            runLen[b] = (s == lastS[b]) ? runLen[b] + 1 : 1;
            lastS[b]  = s;
            if (!s) armedM[b] = 1'b1;
            if (runLen[b] >= FILT_N && s != filtM[b]) begin
                filtM[b] = s;
                if (s && armedM[b]) begin
                    if (b == 0) startDue.push_back(edgeNo + ACT_DLY);
                    else        setDue.push_back(edgeNo + ACT_DLY);
                end
            end
        end
        doStart = 1'b0;
        doSet   = 1'b0;
        if (startDue.size() > 0 && startDue[0] == edgeNo) begin
            doStart = 1'b1;
            void'(startDue.pop_front());
        end
        if (setDue.size() > 0 && setDue[0] == edgeNo) begin
            doSet = 1'b1;
            void'(setDue.pop_front());
        end
        wasRun = runM;
        tickM  = wasRun && (phaseM == CLK_DIV - 1);
        cmM    = 1'b0;
        if (clrIn) begin
            secM = 0;
        end else if (tickM) begin
            secM = (secM + 1) % 60;
            cmM  = (secM == 0);
        end else if (doSet && !wasRun) begin
            secM = (secM + 1) % 60;
        end
        if (doStart) runM = !runM;
        if (clrIn || tickM || !wasRun || !runM) phaseM = 0;
        else phaseM = phaseM + 1;
    endtask

    task automatic applyStimulus(input bit st, input bit st2, input bit clr, input int cycles);
        start_stop = st;
        set_sec    = st2;
        clr_sec    = clr;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            modelStep(st, st2, clr);
            @(negedge clk);
            checkOutput("sec", sec, secM);
            checkOutput("count_min", count_min, cmM);
            checkOutput("running", running, runM);
        end
    endtask

    task automatic pressButton(input int which, input int hold);
        applyStimulus(which == 0, which == 1, 1'b0, hold);
        applyStimulus(1'b0, 1'b0, 1'b0, SETTLE);
    endtask

    task automatic waitSec(input int target, input int budget, input string tag);
        int n = 0;
        while (sec != target && n < budget) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1);
            n++;
        end
        checkOutput(tag, sec, target);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        int n;
        int op;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset_sec", sec, 0);
        checkOutput("reset_running", running, 0);
        checkOutput("reset_count_min", count_min, 0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4);

        $display("[TB] test 1: start and count");
        applyStimulus(1'b1, 1'b0, 1'b0, HOLD);
        n = 0;
        while (running != 1'b1 && n < 20) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1);
            n++;
        end
        checkOutput("t1_running", running, 1);
        checkOutput("t1_sec_start", sec, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 3);
        checkOutput("t1_sec_before_tick", sec, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("t1_sec1", sec, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);
        checkOutput("t1_sec2", sec, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);
        checkOutput("t1_sec3", sec, 3);

        $display("[TB] test 2: wrap and minute carry");
        waitSec(59, 300, "t2_reach59");
        n = 0;
        while (sec == 6'd59 && n < 8) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1);
            n++;
        end
        checkOutput("t2_wrap_sec", sec, 0);
        checkOutput("t2_carry", count_min, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("t2_carry_end", count_min, 0);

        $display("[TB] test 4: clear on the wrap tick");
        waitSec(59, 300, "t4_reach59");
        applyStimulus(1'b0, 1'b0, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput("t4_clr_sec", sec, 0);
        checkOutput("t4_clr_carry", count_min, 0);
        checkOutput("t4_clr_running", running, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("t4_no_late_carry", count_min, 0);

        $display("[TB] test 6: asynchronous reset while running");
        waitSec(30, 200, "t6_reach30");
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("t6_async_sec", sec, 0);
        checkOutput("t6_async_running", running, 0);
        checkOutput("t6_async_carry", count_min, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 3);

        $display("[TB] test 3: set presses in stop");
        for (int i = 0; i < 58; i++) begin
            pressButton(1, HOLD);
        end
        checkOutput("t3_sec58", sec, 58);
        for (int i = 0; i < 3; i++) begin
            pressButton(1, HOLD);
            checkOutput("t3_set_sec", sec, exp3[i]);
            checkOutput("t3_set_carry", count_min, 0);
        end

        $display("[TB] test 5: short set pulse then long press");
        applyStimulus(1'b0, 1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, SETTLE);
        checkOutput("t5_short_press", sec, GLITCH_EXP);
        applyStimulus(1'b0, 1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, SETTLE);
        checkOutput("t5_long_press", sec, GLITCH_EXP + 1);

        $display("[TB] test 7: button held through reset");
        start_stop = 1'b1;
        rst        = 1'b1;
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 15);
        checkOutput("t7_held_no_pulse", running, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, SETTLE);
        pressButton(0, HOLD);
        checkOutput("t7_press_after_release", running, 1);

        $display("[TB] random phase");
        for (int k = 0; k < 150; k++) begin
            op = $urandom_range(0, 6);
            case (op)
                0: begin
                    applyStimulus(1'b1, 1'b0, 1'b0, $urandom_range(1, 8));
                    applyStimulus(1'b0, 1'b0, 1'b0, $urandom_range(1, 12));
                end
                1, 2: begin
                    applyStimulus(1'b0, 1'b1, 1'b0, $urandom_range(1, 8));
                    applyStimulus(1'b0, 1'b0, 1'b0, $urandom_range(1, 12));
                end
                3: applyStimulus(1'b0, 1'b0, 1'b1, $urandom_range(1, 2));
                4, 5: applyStimulus(1'b0, 1'b0, 1'b0, $urandom_range(1, 25));
                default: begin
                    for (int j = 0; j < 6; j++) begin
                        applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                                      $urandom_range(0, 7) == 0, 1);
                    end
                end
            endcase
        end
        applyStimulus(1'b0, 1'b0, 1'b0, SETTLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_second.md
COUNT_SECOND -- requirements
Module: count_second

Interface
REQ-001 Parameter CLK_DIV, default 50_000_000: clk cycles per one-second tick; legal range 2 to 2^26.
REQ-002 Parameter DB_CYCLES, default 16: debounce stability window in clk cycles; used only when SEC_DEBOUNCE_EN is defined.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start_stop  input  1  asynchronous button level; each rising edge toggles RUN/STOP.
REQ-006 set_sec  input  1  asynchronous button level; each rising edge increments sec while in STOP.
REQ-007 clr_sec  input  1  synchronous level; clears seconds and prescaler.
REQ-008 sec  output  6  current seconds value, 0..59, registered.
REQ-009 count_min  output  1  one-cycle carry pulse to the downstream minute counter, registered.
REQ-010 running  output  1  high in RUN state, registered.

Function
REQ-011 start_stop and set_sec SHALL each pass through a 2-flop synchronizer followed by a rising-edge detector that produces a one-cycle internal pulse.
REQ-012 Without debounce, the action of a button rise SHALL be visible on the outputs at the 3rd clk edge after the input rises.
REQ-013 The FSM SHALL have two states: STOP and RUN.
REQ-014 A start_stop pulse SHALL toggle the state, STOP->RUN or RUN->STOP.
REQ-015 The prescaler SHALL count 0..CLK_DIV-1 only in RUN, and SHALL be held at 0 in STOP.
REQ-016 The internal tick SHALL assert for one cycle when the prescaler equals CLK_DIV-1; the prescaler then returns to 0.
REQ-017 On a tick, sec SHALL increment by 1; from 59 it SHALL wrap to 0.
REQ-018 count_min SHALL be high exactly in the single cycle in which sec first reads 0 after a 59->0 tick wrap.
REQ-019 A set_sec pulse in STOP SHALL increment sec by 1 (59 wraps to 0) and SHALL never assert count_min.
REQ-020 A set_sec pulse in RUN SHALL be ignored.
REQ-021 clr_sec high SHALL take highest priority: next cycle sec=0, prescaler=0, count_min=0; any coincident tick or set pulse is discarded; FSM state is unchanged.
REQ-022 A start_stop pulse coinciding with a tick SHALL still apply that tick, and the state SHALL toggle in the same cycle.
REQ-023 sec SHALL never hold a value above 59.

Reset
REQ-024 While rst is high, sec=0, count_min=0, running=0 (STOP), prescaler=0, synchronizer and edge registers=0, and debounce counters=0.
REQ-025 After rst falls, a button already held high SHALL NOT generate a pulse until it is released and pressed again.
REQ-026 Reset asserted mid-count SHALL abort any pending count_min.

Configuration
REQ-027 With macro SEC_DEBOUNCE_EN defined, each synchronized button SHALL update its filtered level only after DB_CYCLES consecutive identical samples, and the edge detector SHALL act on the filtered level; action latency becomes 3+DB_CYCLES edges, and glitches shorter than DB_CYCLES cycles SHALL be ignored.
REQ-028 Without SEC_DEBOUNCE_EN, no filter logic SHALL be present, and REQ-012 timing SHALL apply.

Verification (CLK_DIV=4, DB_CYCLES=4)
REQ-029 Test 1: rst pulse, then start_stop press -> running=1; sec counts 1,2,3 with 4 clk cycles between increments.
REQ-030 Test 2: run to sec=59, then the next tick -> sec=0 and count_min=1 for exactly 1 cycle, then count_min=0.
REQ-031 Test 3: in STOP, with sec=58, three set_sec presses -> sec reads 59, 0, 1, and count_min stays 0 throughout.
REQ-032 Test 4: in RUN, clr_sec asserted on the cycle the 59->0 tick would occur -> sec=0, count_min=0, running stays 1.
REQ-033 Test 5: with SEC_DEBOUNCE_EN, a 2-cycle set_sec glitch in STOP -> sec unchanged; a 10-cycle press -> sec+1.
REQ-034 Test 6: rst asserted while in RUN at sec=30 -> sec=0, running=0 immediately, without waiting for a clk edge.
